// File: rtl/matmul_out_pkg.sv
// Shared types and arithmetic helpers for the matmul output collector.
package matmul_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Working width of the add helper; operands are sign-extended into it.
    localparam int ADD_W = 64;

    // Signed add of two sign-extended operands. The sum is either wrapped
    // back into `width` bits or clamped to the signed range of `width` bits.
    // The result comes back sign-extended; callers keep the low `width` bits.
    function automatic logic signed [ADD_W-1:0] add_word(
        input logic signed [ADD_W-1:0] a,
        input logic signed [ADD_W-1:0] b,
        input int                      width,
        input logic                    saturate
    );
        logic signed [ADD_W-1:0] sum;
        logic signed [ADD_W-1:0] max_v;
        logic signed [ADD_W-1:0] min_v;
        logic signed [ADD_W-1:0] res;
        sum   = a + b;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (saturate) begin
            if (sum > max_v) begin
                res = max_v;
            end else if (sum < min_v) begin
                res = min_v;
            end else begin
                res = sum;
            end
        end else begin
            res = (sum <<< (ADD_W - width)) >>> (ADD_W - width);
        end
        return res;
    endfunction

endpackage

// File: rtl/matmul_col_capture.sv
// One column / one source capture lane: hold counter gating acceptance,
// row counter selecting the accumulator, ROWS accumulators, sticky overflow.
module matmul_col_capture
    import matmul_out_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int WORD_SIZE   = 16,
    parameter int HOLD_CYCLES = 2,
    parameter int SATURATE    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        capture_en,
    input  logic                        stall,
    input  logic                        valid,
    input  logic [WORD_SIZE-1:0]        data,
    output logic [ROWS*WORD_SIZE-1:0]   acc_flat,
    output logic                        overflow
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int ROW_W  = $clog2(ROWS + 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [ROW_W-1:0]     row_cnt_q, row_cnt_d;
    logic                 overflow_q, overflow_d;
    logic [WORD_SIZE-1:0] acc_q [ROWS];
    logic [WORD_SIZE-1:0] acc_d [ROWS];

    // Acceptance decision and next values of counters and accumulators.
    always_comb begin
        hold_d     = hold_q;
        row_cnt_d  = row_cnt_q;
        overflow_d = overflow_q;
        for (int r = 0; r < ROWS; r++) begin
            acc_d[r] = acc_q[r];
        end
        if (clear) begin
            hold_d     = '0;
            row_cnt_d  = '0;
            overflow_d = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                acc_d[r] = '0;
            end
        end else if (capture_en && !stall) begin
            if (!valid) begin
                hold_d = '0;
            end else if (hold_q != '0) begin
                hold_d = hold_q - HOLD_W'(1);
            end else begin
                // Word accepted; the remaining hold cycles belong to it.
                hold_d = HOLD_RELOAD;
                if (row_cnt_q == ROW_W'(ROWS)) begin
                    overflow_d = 1'b1;
                end else begin
                    row_cnt_d = row_cnt_q + ROW_W'(1);
                    for (int r = 0; r < ROWS; r++) begin
                        if (row_cnt_q == ROW_W'(r)) begin
                            acc_d[r] = WORD_SIZE'(add_word(ADD_W'(signed'(acc_q[r])),
                                                           ADD_W'(signed'(data)),
                                                           WORD_SIZE, SATURATE != 0));
                        end else begin
                            acc_d[r] = acc_q[r];
                        end
                    end
                end
            end
        end else begin
            hold_d = hold_q;
        end
    end

    // Lane state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q     <= '0;
            row_cnt_q  <= '0;
            overflow_q <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                acc_q[r] <= '0;
            end
        end else begin
            hold_q     <= hold_d;
            row_cnt_q  <= row_cnt_d;
            overflow_q <= overflow_d;
            for (int r = 0; r < ROWS; r++) begin
                acc_q[r] <= acc_d[r];
            end
        end
    end

    // Flatten accumulators, row 0 in the LSBs.
    always_comb begin
        acc_flat = '0;
        for (int r = 0; r < ROWS; r++) begin
            acc_flat[r*WORD_SIZE +: WORD_SIZE] = acc_q[r];
        end
    end

    assign overflow = overflow_q;

endmodule

// File: rtl/matmul_output_collector.sv
// Collects systolic-array and proxy column outputs into a ROWS x COLS
// result, then writes it out row-major as memory beats with req/gnt.
module matmul_output_collector
    import matmul_out_pkg::*;
#(
    parameter int          ROWS           = 4,
    parameter int          COLS           = 4,
    parameter int          WORD_SIZE      = 16,
    parameter int          MEM_PORT_WIDTH = 64,
    parameter int          HOLD_CYCLES    = 2,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          ADDR_INCR      = 4,
    parameter int          SATURATE       = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          fsm_done,
    input  logic [COLS-1:0]               sa_valid,
    input  logic [COLS*WORD_SIZE-1:0]     sa_data,
    input  logic [COLS-1:0]               proxy_valid,
    input  logic [COLS*WORD_SIZE-1:0]     proxy_data,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic                          mem_req,
    input  logic                          mem_gnt,
    output logic [31:0]                   mem_addr,
    output logic [MEM_PORT_WIDTH-1:0]     mem_wdata,
    output logic                          mem_last
);

    localparam int MAT_W  = ROWS * COLS * WORD_SIZE;
    localparam int NBEATS = MAT_W / MEM_PORT_WIDTH;
    localparam int BEAT_W = $clog2(NBEATS) + 1;

    state_e                    state_q, state_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [BEAT_W-1:0]         next_beat_s;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overflow_q, overflow_d;
    logic                      mem_req_q, mem_req_d;
    logic                      mem_last_q, mem_last_d;
    logic [31:0]               mem_addr_q, mem_addr_d;
    logic [MEM_PORT_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                      clear_s;
    logic                      capture_en_s;
    logic [ROWS*WORD_SIZE-1:0] sa_acc_s [COLS];
    logic [ROWS*WORD_SIZE-1:0] px_acc_s [COLS];
    logic [COLS-1:0]           sa_ovf_s;
    logic [COLS-1:0]           px_ovf_s;
    logic [MAT_W-1:0]          matrix_s;

    assign capture_en_s = (state_q == ST_COLLECT);
    assign next_beat_s  = beat_q + BEAT_W'(1);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        matmul_col_capture #(
            .ROWS(ROWS), .WORD_SIZE(WORD_SIZE),
            .HOLD_CYCLES(HOLD_CYCLES), .SATURATE(SATURATE)
        ) u_sa (
            .clk(clk), .rst(rst), .clear(clear_s), .capture_en(capture_en_s),
            .stall(stall), .valid(sa_valid[c]),
            .data(sa_data[c*WORD_SIZE +: WORD_SIZE]),
            .acc_flat(sa_acc_s[c]), .overflow(sa_ovf_s[c])
        );
        matmul_col_capture #(
            .ROWS(ROWS), .WORD_SIZE(WORD_SIZE),
            .HOLD_CYCLES(HOLD_CYCLES), .SATURATE(SATURATE)
        ) u_px (
            .clk(clk), .rst(rst), .clear(clear_s), .capture_en(capture_en_s),
            .stall(stall), .valid(proxy_valid[c]),
            .data(proxy_data[c*WORD_SIZE +: WORD_SIZE]),
            .acc_flat(px_acc_s[c]), .overflow(px_ovf_s[c])
        );
    end

    // Combine array and proxy accumulators into the row-major result matrix.
    always_comb begin
        matrix_s = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                matrix_s[(r*COLS + c)*WORD_SIZE +: WORD_SIZE] =
                    WORD_SIZE'(add_word(ADD_W'(signed'(sa_acc_s[c][r*WORD_SIZE +: WORD_SIZE])),
                                        ADD_W'(signed'(px_acc_s[c][r*WORD_SIZE +: WORD_SIZE])),
                                        WORD_SIZE, SATURATE != 0));
            end
        end
    end

    // Job FSM: next state, beat sequencing and next values of all outputs.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        done_d      = 1'b0;
        mem_req_d   = mem_req_q;
        mem_last_d  = mem_last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        clear_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_COLLECT;
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (fsm_done) begin
                    state_d     = ST_WRITE;
                    beat_d      = '0;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = BASE_ADDR;
                    mem_wdata_d = matrix_s[MEM_PORT_WIDTH-1:0];
                    mem_last_d  = (NBEATS == 1);
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                if (mem_req_q && mem_gnt) begin
                    if (mem_last_q) begin
                        state_d    = ST_DONE;
                        mem_req_d  = 1'b0;
                        mem_last_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        beat_d      = next_beat_s;
                        mem_addr_d  = BASE_ADDR + 32'(ADDR_INCR) * 32'(next_beat_s);
                        mem_wdata_d = matrix_s[32'(next_beat_s)*MEM_PORT_WIDTH +: MEM_PORT_WIDTH];
                        mem_last_d  = (next_beat_s == BEAT_W'(NBEATS - 1));
                    end
                end else begin
                    // Beat not granted: everything on the port stays put.
                    mem_req_d = mem_req_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        if (clear_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q | (|sa_ovf_s) | (|px_ovf_s);
        end
    end

    // Control and output registers; reset abandons any beat in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_last_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            mem_req_q   <= mem_req_d;
            mem_last_q  <= mem_last_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
    assign mem_req   = mem_req_q;
    assign mem_last  = mem_last_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_matmul_output_collector.sv
// Directed bench for matmul_output_collector: a wrapping and a saturating
// instance share all inputs; element expectations come from a hand table.
module tb_matmul_output_collector;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int W    = 16;
    localparam int MPW  = 64;
    localparam int NB   = 4;

    logic              clk = 1'b0;
    logic              rst, start, stall, fsm_done, mem_gnt;
    logic [COLS-1:0]   sa_valid, proxy_valid;
    logic [COLS*W-1:0] sa_data, proxy_data;
    logic              busy, done, overflow, mem_req, mem_last;
    logic [31:0]       mem_addr;
    logic [MPW-1:0]    mem_wdata;
    logic              s_busy, s_done, s_overflow, s_mem_req, s_mem_last;
    logic [31:0]       s_mem_addr;
    logic [MPW-1:0]    s_mem_wdata;

    always #5 clk = ~clk;

    matmul_output_collector dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .fsm_done(fsm_done),
        .sa_valid(sa_valid), .sa_data(sa_data),
        .proxy_valid(proxy_valid), .proxy_data(proxy_data),
        .busy(busy), .done(done), .overflow(overflow),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_last(mem_last)
    );

    matmul_output_collector #(.SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .fsm_done(fsm_done),
        .sa_valid(sa_valid), .sa_data(sa_data),
        .proxy_valid(proxy_valid), .proxy_data(proxy_data),
        .busy(s_busy), .done(s_done), .overflow(s_overflow),
        .mem_req(s_mem_req), .mem_gnt(mem_gnt), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_last(s_mem_last)
    );

    typedef struct {
        int         row;
        int         col;
        logic [W-1:0] sa;
        logic [W-1:0] px;
        logic [W-1:0] exp_wrap;
        logic [W-1:0] exp_sat;
    } vec_t;

    vec_t         tbl [8];
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] sa_m  [ROWS][COLS];
    logic [W-1:0] px_m  [ROWS][COLS];
    logic [W-1:0] exp_m [ROWS][COLS];
    logic [W-1:0] exps_m[ROWS][COLS];
    logic [MPW-1:0] cap_w [NB];
    logic [MPW-1:0] cap_s [NB];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", nm, act, exp);
        end
    endtask

    function automatic logic [MPW-1:0] exp_beat(input int n, input logic sat);
        logic [MPW-1:0] b;
        b = '0;
        for (int c = 0; c < COLS; c++) begin
            b[c*W +: W] = sat ? exps_m[n][c] : exp_m[n][c];
        end
        return b;
    endfunction

    task automatic clear_mats();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                sa_m[r][c] = '0; px_m[r][c] = '0;
                exp_m[r][c] = '0; exps_m[r][c] = '0;
            end
        end
    endtask

    task automatic job_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check1("busy_after_start", busy, 1'b1);
        check1("ovf_clear_at_start", overflow, 1'b0);
    endtask

    // Present each row on every enabled column for two cycles.
    task automatic drive_matrix();
        logic [COLS-1:0] sa_en, px_en;
        sa_en = '0; px_en = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (sa_m[r][c] != '0) sa_en[c] = 1'b1;
                if (px_m[r][c] != '0) px_en[c] = 1'b1;
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                sa_data[c*W +: W]    = sa_m[r][c];
                proxy_data[c*W +: W] = px_m[r][c];
            end
            for (int h = 0; h < 2; h++) begin
                sa_valid = sa_en; proxy_valid = px_en;
                tick();
            end
        end
        sa_valid = '0; proxy_valid = '0;
        tick();
    endtask

    // Pulse fsm_done and take all beats; beat sb sees sc cycles of mem_gnt=0.
    task automatic do_write(input int sb, input int sc);
        check1("req_before_done", mem_req, 1'b0);
        mem_gnt  = 1'b1;
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        for (int n = 0; n < NB; n++) begin
            if (n == sb) begin
                mem_gnt = 1'b0;
                for (int k = 0; k < sc; k++) begin
                    tick();
                    check1("req_held", mem_req, 1'b1);
                    checkw("addr_held", 64'(mem_addr), 64'(32'(n * 4)));
                    checkw("wdata_held", 64'(mem_wdata), 64'(exp_beat(n, 1'b0)));
                end
                mem_gnt = 1'b1;
            end
            check1("beat_req", mem_req, 1'b1);
            checkw("beat_addr", 64'(mem_addr), 64'(32'(n * 4)));
            checkw("sat_beat_addr", 64'(s_mem_addr), 64'(32'(n * 4)));
            check1("beat_last", mem_last, (n == NB - 1));
            checkw("beat_wdata", 64'(mem_wdata), 64'(exp_beat(n, 1'b0)));
            checkw("sat_beat_wdata", 64'(s_mem_wdata), 64'(exp_beat(n, 1'b1)));
            cap_w[n] = mem_wdata;
            cap_s[n] = s_mem_wdata;
            tick();
        end
        check1("done_pulse", done, 1'b1);
        check1("sat_done_pulse", s_done, 1'b1);
        check1("busy_in_done", busy, 1'b1);
        check1("req_after_last", mem_req, 1'b0);
        check1("sat_req_after_last", s_mem_req, 1'b0);
        tick();
        check1("done_one_cycle", done, 1'b0);
        check1("idle_not_busy", busy, 1'b0);
    endtask

    initial begin
        // element (row,col): sa word, proxy word, wrapped result, saturated result
        tbl[0] = '{0, 0, 16'h0001, 16'h0000, 16'h0001, 16'h0001};
        tbl[1] = '{1, 0, 16'h0002, 16'h0000, 16'h0002, 16'h0002};
        tbl[2] = '{2, 0, 16'h0003, 16'h0000, 16'h0003, 16'h0003};
        tbl[3] = '{3, 0, 16'h0004, 16'h0000, 16'h0004, 16'h0004};
        tbl[4] = '{0, 1, 16'h0005, 16'h0003, 16'h0008, 16'h0008};
        tbl[5] = '{1, 2, 16'h0000, 16'h1234, 16'h1234, 16'h1234};
        tbl[6] = '{0, 3, 16'h7FF0, 16'h0100, 16'h80F0, 16'h7FFF};
        tbl[7] = '{2, 3, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000};

        rst = 1'b1; start = 1'b0; stall = 1'b0; fsm_done = 1'b0; mem_gnt = 1'b0;
        sa_valid = '0; proxy_valid = '0; sa_data = '0; proxy_data = '0;
        tick(); tick();
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_ovf", overflow, 1'b0);
        check1("rst_req", mem_req, 1'b0);
        check1("rst_last", mem_last, 1'b0);
        checkw("rst_addr", 64'(mem_addr), 64'h0);
        checkw("rst_wdata", 64'(mem_wdata), 64'h0);
        check1("rst_sat_busy", s_busy, 1'b0);
        check1("rst_sat_ovf", s_overflow, 1'b0);
        check1("rst_sat_last", s_mem_last, 1'b0);
        rst = 1'b0;
        tick();

        // Job 1: table contents, immediate grants.
        clear_mats();
        for (int i = 0; i < 8; i++) begin
            sa_m[tbl[i].row][tbl[i].col]   = tbl[i].sa;
            px_m[tbl[i].row][tbl[i].col]   = tbl[i].px;
            exp_m[tbl[i].row][tbl[i].col]  = tbl[i].exp_wrap;
            exps_m[tbl[i].row][tbl[i].col] = tbl[i].exp_sat;
        end
        job_start();
        drive_matrix();
        do_write(-1, 0);
        for (int i = 0; i < 8; i++) begin
            checkw($sformatf("elem_r%0d_c%0d", tbl[i].row, tbl[i].col),
                   64'(cap_w[tbl[i].row][tbl[i].col*W +: W]), 64'(tbl[i].exp_wrap));
            checkw($sformatf("sat_elem_r%0d_c%0d", tbl[i].row, tbl[i].col),
                   64'(cap_s[tbl[i].row][tbl[i].col*W +: W]), 64'(tbl[i].exp_sat));
        end
        check1("job1_no_ovf", overflow, 1'b0);

        // Job 2: same data again (accumulators must restart), grant withheld on beat 1.
        job_start();
        drive_matrix();
        do_write(1, 3);

        // Job 3: five words on column 3 with a stall inside the first hold.
        clear_mats();
        job_start();
        sa_data = '0;
        sa_data[3*W +: W] = 16'd10;
        sa_valid = 4'b1000;
        tick();
        stall = 1'b1;
        tick(); tick();
        stall = 1'b0;
        tick();
        for (int w = 2; w <= 5; w++) begin
            sa_data[3*W +: W] = 16'(w * 10);
            tick(); tick();
        end
        sa_valid = '0;
        tick(); tick();
        check1("ovf_5th_word", overflow, 1'b1);
        check1("sat_ovf_5th_word", s_overflow, 1'b1);
        for (int r = 0; r < ROWS; r++) begin
            exp_m[r][3]  = 16'((r + 1) * 10);
            exps_m[r][3] = 16'((r + 1) * 10);
        end
        do_write(-1, 0);
        check1("ovf_sticky", overflow, 1'b1);

        // Job 4: reset while beat 2 is outstanding.
        clear_mats();
        job_start();
        mem_gnt = 1'b1;
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
        tick(); tick();
        checkw("beat2_addr_pre_rst", 64'(mem_addr), 64'h8);
        mem_gnt = 1'b0;
        rst = 1'b1;
        #1;
        check1("rst_req_async", mem_req, 1'b0);
        check1("rst_busy_async", busy, 1'b0);
        checkw("rst_addr_async", 64'(mem_addr), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        fsm_done = 1'b1;
        tick(); tick();
        fsm_done = 1'b0;
        check1("no_req_without_start", mem_req, 1'b0);
        check1("idle_after_rst", busy, 1'b0);

        // Job 5: fresh job after reset starts from BASE_ADDR with zero data.
        job_start();
        do_write(-1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/matmul_output_collector.md
MATMUL_OUTPUT_COLLECTOR -- requirements
Module: matmul_output_collector

Interface
REQ-001 SHALL have parameter ROWS, default 4, output matrix rows.
REQ-002 SHALL have parameter COLS, default 4, output matrix columns / systolic columns.
REQ-003 SHALL have parameter WORD_SIZE, default 16, signed element width.
REQ-004 SHALL have parameter MEM_PORT_WIDTH, default 64, memory write data width; COLS*WORD_SIZE is an integer multiple of it.
REQ-005 SHALL have parameter HOLD_CYCLES, default 2, cycles each column output word is held valid.
REQ-006 SHALL have parameters BASE_ADDR (default 32'h0) and ADDR_INCR (default 4), beat address base and step.
REQ-007 SHALL have parameter SATURATE, default 0: 0 = wrap, 1 = signed saturating add.
REQ-008 SHALL have ports: clk in 1, clock; rst in 1, reset; one clock, reset is asynchronous and active-high.
REQ-009 SHALL have ports: start in 1, begin job; stall in 1, freeze capture; fsm_done in 1, matmul compute finished.
REQ-010 SHALL have ports: sa_valid in COLS, sa_data in COLS*WORD_SIZE, per-column array outputs.
REQ-011 SHALL have ports: proxy_valid in COLS, proxy_data in COLS*WORD_SIZE, per-column proxy (repair) outputs.
REQ-012 SHALL have ports: busy out 1; done out 1, one-cycle pulse; overflow out 1, sticky.
REQ-013 SHALL have ports: mem_req out 1; mem_gnt in 1; mem_addr out 32; mem_wdata out MEM_PORT_WIDTH; mem_last out 1.

Function
REQ-014 SHALL implement FSM IDLE -> COLLECT (start) -> WRITE (fsm_done) -> DONE -> IDLE; start outside IDLE ignored.
REQ-015 SHALL, on the IDLE->COLLECT transition, clear all accumulators, row counters, hold counters and overflow.
REQ-016 SHALL, per column and per source (sa, proxy), accept a word when valid=1, stall=0, hold counter=0; then count HOLD_CYCLES-1 further valid cycles before next acceptance; valid=0 zeroes the hold counter.
REQ-017 SHALL, when stall=1, neither accept words nor advance hold counters.
REQ-018 SHALL add each accepted word into acc[row_cnt][col] of its source, then increment that row_cnt; sa and proxy tracked independently.
REQ-019 SHALL ignore words accepted with row_cnt=ROWS and set overflow.
REQ-020 SHALL capture only in COLLECT; accumulation across repeated tiles in one job is additive.
REQ-021 SHALL form output element = sa_acc + proxy_acc, wrapped to WORD_SIZE (SATURATE=0) or clamped to signed min/max (SATURATE=1); same rule for per-word accumulation.
REQ-022 SHALL, in WRITE, emit ROWS*COLS*WORD_SIZE/MEM_PORT_WIDTH beats, row-major, column 0 in LSBs, beat n at BASE_ADDR+n*ADDR_INCR.
REQ-023 SHALL assert mem_req from the cycle after fsm_done is sampled, holding mem_addr/mem_wdata/mem_last stable until mem_gnt=1; a beat completes on mem_req&&mem_gnt.
REQ-024 SHALL present the next beat in the cycle after a grant (back-to-back when mem_gnt stays 1); mem_last=1 only on final beat.
REQ-025 SHALL enter DONE after final beat grant, pulse done one cycle, then IDLE; busy=1 in COLLECT/WRITE/DONE.
REQ-026 SHALL ignore stall, sa_valid and proxy_valid during WRITE.

Reset
REQ-027 SHALL, on rst, asynchronously force IDLE, busy=0, done=0, overflow=0, mem_req=0, mem_last=0, mem_addr=0, mem_wdata=0, all counters and accumulators 0.
REQ-028 SHALL abandon any in-flight beat on rst mid-WRITE; no further mem_req until a new start and fsm_done.

Structure
REQ-029 SHALL place state enum and signed saturating/wrapping add function in package matmul_out_pkg.
REQ-030 SHALL use sub-module matmul_col_capture (hold counter, row counter, ROWS accumulators, overflow) instantiated 2*COLS times.

Verification
REQ-031 SHALL test: defaults, HOLD_CYCLES=2, sa rows col0 = 1,2,3,4 each held 2 cycles, proxy 0 -> beat0 wdata low word = 1, row1 beat low word = 2, 4 beats granted immediately, done at cycle after last grant.
REQ-032 SHALL test: sa=5, proxy=3 same element -> written 8; proxy only on col2 with sa 0 -> that element equals proxy value.
REQ-033 SHALL test: SATURATE=1, sa 0x7FF0 + proxy 0x0100 -> 0x7FFF; SATURATE=0 -> 0x80F0.
REQ-034 SHALL test: mem_gnt low 3 cycles on beat 1 -> addr 0x4 and data stable throughout, beat 2 follows grant by 1 cycle.
REQ-035 SHALL test: 5 words on col3 with ROWS=4 -> overflow=1, 5th word absent; stall=1 for 2 cycles mid-hold -> no extra acceptance.
REQ-036 SHALL test: rst asserted during beat 2 -> mem_req falls asynchronously, FSM IDLE, new job restarts at BASE_ADDR.
